// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   arb_state_t     : arbiter FSM states (ARB, WAIT, PULSE, HOLD)
//   UART_THR_ADDR   : UART transmit holding register address
//   DEFAULT_HOLDOFF : default write-to-sample holdoff in cycles
//   DEFAULT_TIMEOUT : default mid-packet idle limit in cycles
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    WAIT  = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } arb_state_t;

  localparam logic [2:0] UART_THR_ADDR   = 3'b000;
  localparam int         DEFAULT_HOLDOFF = 4;
  localparam int         DEFAULT_TIMEOUT = 27_000_000;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: returns the first set request at or above ptr,
// wrapping past N-1 back to 0.
//   req : request vector (N bits)
//   ptr : index with highest priority this cycle (must be < N)
//   idx : index of the selected request (0 when none)
//   any : at least one request is set
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] dbl;
  logic [2*N-1:0] rot;

  // Rotating a doubled copy puts req[(ptr+k) mod N] at bit k.
  assign dbl = {req, req};
  assign rot = dbl >> ptr;

  always_comb begin
    idx = '0;
    any = 1'b0;
    // Walk downward so the lowest rotated position wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = PW'((int'(ptr) + k) % N);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter between
// N_REQ byte-stream producers, and sequencer for the UART write interface.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req_valid    : per-requester byte available
//   req_data     : per-requester byte
//   req_last     : per-requester end-of-packet marker
//   req_ready    : byte of the current owner accepted (only owner, only WAIT)
//   tx_rdy_n     : UART TxRDYn, low when the holding register is free
//   tx_en        : one-cycle UART write pulse
//   waddr, wdata : UART write address (always THR) and data
//   grant, busy  : current owner index and lock-held flag
//   timeout_err  : one-cycle pulse when a stalled lock is dropped
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ   = 2,
  parameter  int HOLDOFF = DEFAULT_HOLDOFF,
  parameter  int TIMEOUT = DEFAULT_TIMEOUT,
  localparam int GW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0][7:0] req_data,
  input  logic [N_REQ-1:0]      req_last,
  output logic [N_REQ-1:0]      req_ready,
  input  logic                  tx_rdy_n,
  output logic                  tx_en,
  output logic [2:0]            waddr,
  output logic [7:0]            wdata,
  output logic [GW-1:0]         grant,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int IW = $clog2(TIMEOUT);

  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [GW-1:0] LAST_IDX  = GW'(N_REQ - 1);

  arb_state_t    state;
  logic [GW-1:0] rr_ptr;
  logic          last_q;
  logic [HW-1:0] hold_cnt;
  logic [IW-1:0] idle_cnt;

  logic [GW-1:0] pick_idx;
  logic          pick_any;
  logic          xfer;
  logic [GW-1:0] next_ptr;

  rr_pick #(
    .N  (N_REQ),
    .PW (GW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign xfer     = (state == WAIT) && req_valid[grant] && !tx_rdy_n;
  assign next_ptr = (grant == LAST_IDX) ? '0 : grant + 1'b1;
  assign waddr    = UART_THR_ADDR;

  // Ready is combinational from tx_rdy_n so a byte can move in its first
  // WAIT cycle; non-owners never see ready.
  always_comb begin
    req_ready = '0;
    if (state == WAIT) req_ready[grant] = ~tx_rdy_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ARB;
      rr_ptr      <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      tx_en       <= 1'b0;
      wdata       <= 8'h00;
      timeout_err <= 1'b0;
      last_q      <= 1'b0;
      hold_cnt    <= '0;
      idle_cnt    <= '0;
    end else begin
      tx_en       <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        ARB: begin
          if (pick_any) begin
            grant    <= pick_idx;
            busy     <= 1'b1;
            idle_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A transfer on the expiry cycle wins over the timeout.
          if (xfer) begin
            wdata    <= req_data[grant];
            last_q   <= req_last[grant];
            tx_en    <= 1'b1;
            idle_cnt <= '0;
            state    <= PULSE;
          end else if (idle_cnt == IDLE_LAST) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            rr_ptr      <= next_ptr;
            idle_cnt    <= '0;
            state       <= ARB;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        PULSE: begin
          hold_cnt <= HOLD_LOAD;
          state    <= HOLD;
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            if (last_q) begin
              busy   <= 1'b0;
              rr_ptr <= next_ptr;
              state  <= ARB;
            end else begin
              state <= WAIT;
            end
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: three instances (N=2 long timeout, N=2 with
// TIMEOUT=16, N=4) share one set of stimulus signals; a selector picks which
// instance is observed. Expected byte/owner order comes from a packet-level
// round-robin model over the per-requester packet lists.
module tb_uart_tx_arbiter;

  localparam int H = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [3:0][7:0] req_data;
  logic [3:0]      req_last;
  logic            tx_rdy_n;

  always #5 clk = ~clk;

  logic [1:0] a_ready, t_ready;
  logic [3:0] f_ready;
  logic       a_tx_en, t_tx_en, f_tx_en;
  logic [2:0] a_waddr, t_waddr, f_waddr;
  logic [7:0] a_wdata, t_wdata, f_wdata;
  logic [0:0] a_grant, t_grant;
  logic [1:0] f_grant;
  logic       a_busy, t_busy, f_busy;
  logic       a_terr, t_terr, f_terr;

  uart_tx_arbiter #(.N_REQ(2), .HOLDOFF(H), .TIMEOUT(1000)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1:0]), .req_data(req_data[1:0]),
    .req_last(req_last[1:0]), .req_ready(a_ready), .tx_rdy_n(tx_rdy_n), .tx_en(a_tx_en),
    .waddr(a_waddr), .wdata(a_wdata), .grant(a_grant), .busy(a_busy), .timeout_err(a_terr));

  uart_tx_arbiter #(.N_REQ(2), .HOLDOFF(H), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1:0]), .req_data(req_data[1:0]),
    .req_last(req_last[1:0]), .req_ready(t_ready), .tx_rdy_n(tx_rdy_n), .tx_en(t_tx_en),
    .waddr(t_waddr), .wdata(t_wdata), .grant(t_grant), .busy(t_busy), .timeout_err(t_terr));

  uart_tx_arbiter #(.N_REQ(4), .HOLDOFF(H), .TIMEOUT(1000)) dut_4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(f_ready), .tx_rdy_n(tx_rdy_n), .tx_en(f_tx_en),
    .waddr(f_waddr), .wdata(f_wdata), .grant(f_grant), .busy(f_busy), .timeout_err(f_terr));

  int         sel;
  logic [3:0] m_ready;
  logic       m_tx_en, m_busy, m_terr;
  logic [2:0] m_waddr;
  logic [7:0] m_wdata;
  logic [1:0] m_grant;

  always_comb begin
    m_ready = {2'b00, a_ready}; m_tx_en = a_tx_en; m_waddr = a_waddr; m_wdata = a_wdata;
    m_grant = {1'b0, a_grant}; m_busy = a_busy; m_terr = a_terr;
    case (sel)
      1: begin
        m_ready = {2'b00, t_ready}; m_tx_en = t_tx_en; m_waddr = t_waddr; m_wdata = t_wdata;
        m_grant = {1'b0, t_grant}; m_busy = t_busy; m_terr = t_terr;
      end
      2: begin
        m_ready = f_ready; m_tx_en = f_tx_en; m_waddr = f_waddr; m_wdata = f_wdata;
        m_grant = f_grant; m_busy = f_busy; m_terr = f_terr;
      end
      default: ;
    endcase
  end

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [8:0] mem [4][64];
  int         head [4];
  int         tail [4];
  logic [3:0] s_ready;
  logic       rdy_rand;

  int         n_obs;
  logic [7:0] obs_data [256];
  int         obs_src [256];
  int         obs_cyc [256];
  logic       obs_busy [256];
  int         terr_cnt, terr_cyc;
  int         spacing_viol = 0, ready_viol = 0, waddr_viol = 0;

  logic [7:0] exp_data [256];
  int         exp_src [256];
  int         ne;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_byte(input int r, input logic [7:0] d, input logic last);
    mem[r][tail[r]] = {last, d};
    tail[r]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (head[i] < tail[i]) begin
        req_valid[i] = 1'b1;
        req_data[i]  = mem[i][head[i]][7:0];
        req_last[i]  = mem[i][head[i]][8];
      end else begin
        req_valid[i] = 1'b0;
        req_data[i]  = 8'h00;
        req_last[i]  = 1'b0;
      end
    end
    if (rdy_rand) tx_rdy_n = ($urandom_range(0, 3) == 0);
  endtask

  // One clock: sample outputs at the falling edge, then after the rising
  // edge retire accepted bytes and present the next ones.
  task automatic step();
    @(negedge clk);
    s_ready = m_ready;
    if (m_tx_en) begin
      if (n_obs > 0 && (cyc - obs_cyc[n_obs-1]) < H + 2) spacing_viol++;
      if (m_waddr != 3'b000) waddr_viol++;
      obs_data[n_obs] = m_wdata;
      obs_src[n_obs]  = int'(m_grant);
      obs_cyc[n_obs]  = cyc;
      obs_busy[n_obs] = m_busy;
      n_obs++;
    end
    if (m_terr) begin
      terr_cnt++;
      terr_cyc = cyc;
    end
    for (int i = 0; i < 4; i++)
      if (m_ready[i] && (!m_busy || int'(m_grant) != i)) ready_viol++;
    @(posedge clk);
    cyc++;
    #1;
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && s_ready[i]) head[i]++;
    drive();
  endtask

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rdy_rand = 1'b0;
    tx_rdy_n = 1'b0;
    s_ready = '0;
    clear_queues();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_obs = 0;
    terr_cnt = 0;
    terr_cyc = -1;
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < 4; i++)
      if (head[i] < tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_idle(input int budget, input string tag);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      step();
      n++;
      done = queues_empty() && !m_busy;
    end
    check({tag, " finished"}, 32'(done), 32'd1);
  endtask

  // Packet-level round robin: whole packets in order, next search starts
  // after the requester just served; an unterminated packet ends the lock.
  task automatic build_expected(input int n);
    int pos [4];
    int ptr, c;
    logic lst;
    for (int i = 0; i < 4; i++) pos[i] = 0;
    ptr = 0;
    ne = 0;
    for (int guard = 0; guard < 64; guard++) begin
      c = -1;
      for (int k = 0; k < n; k++)
        if (c < 0 && pos[(ptr + k) % n] < tail[(ptr + k) % n]) c = (ptr + k) % n;
      if (c < 0) break;
      do begin
        exp_data[ne] = mem[c][pos[c]][7:0];
        exp_src[ne]  = c;
        lst = mem[c][pos[c]][8];
        ne++;
        pos[c]++;
      end while (!lst && pos[c] < tail[c]);
      ptr = (c + 1) % n;
    end
  endtask

  task automatic compare(input string tag, input int n);
    int m;
    build_expected(n);
    check({tag, " pulse count"}, n_obs, ne);
    m = (n_obs < ne) ? n_obs : ne;
    for (int i = 0; i < m; i++) begin
      check($sformatf("%s wdata[%0d]", tag, i), obs_data[i], exp_data[i]);
      check($sformatf("%s owner[%0d]", tag, i), obs_src[i], exp_src[i]);
    end
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, " tx_en"}, m_tx_en, 1'b0);
    check({tag, " busy"}, m_busy, 1'b0);
    check({tag, " grant"}, m_grant, 2'd0);
    check({tag, " wdata"}, m_wdata, 8'h00);
    check({tag, " timeout_err"}, m_terr, 1'b0);
    check({tag, " req_ready"}, m_ready, 4'b0000);
    check({tag, " waddr"}, m_waddr, 3'b000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, stall;
    sel = 0;
    rst_n = 1'b0;
    rdy_rand = 1'b0;
    tx_rdy_n = 1'b0;
    n_obs = 0;
    terr_cnt = 0;
    terr_cyc = -1;
    clear_queues();
    add_byte(0, 8'hAA, 1'b1);
    drive();
    #12;
    reset_outputs("reset");

    // Single requester, three-byte packet.
    do_reset();
    add_byte(0, 8'h72, 1'b0); add_byte(0, 8'h65, 1'b0); add_byte(0, 8'h0A, 1'b1);
    drive();
    run_idle(100, "single");
    compare("single", 2);
    check("single gap01", obs_cyc[1] - obs_cyc[0], H + 2);
    check("single gap12", obs_cyc[2] - obs_cyc[1], H + 2);
    check("single busy at 3rd", obs_busy[2], 1'b1);
    check("single busy after", m_busy, 1'b0);

    // Two requesters, 2-byte packets, continuously valid.
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 2; r++) begin
        add_byte(r, 8'($urandom), 1'b0);
        add_byte(r, 8'($urandom), 1'b1);
      end
    drive();
    run_idle(300, "alt");
    compare("alt", 2);
    for (int i = 0; i < 12; i++) check($sformatf("alt order[%0d]", i), obs_src[i], (i / 2) % 2);

    // UART busy for 100 cycles while owner waits.
    do_reset();
    tx_rdy_n = 1'b1;
    add_byte(0, 8'h5A, 1'b1);
    drive();
    repeat (3) step();
    stall = 0;
    repeat (100) begin
      step();
      if (s_ready != 4'b0000) stall++;
    end
    check("stall ready seen", stall, 0);
    check("stall pulses", n_obs, 0);
    check("stall busy", m_busy, 1'b1);
    tx_rdy_n = 1'b0;
    #1;
    check("stall ready on release", m_ready, 4'b0001);
    step();
    check("stall tx_en next", m_tx_en, 1'b1);
    check("stall wdata", m_wdata, 8'h5A);
    run_idle(50, "stall");

    // Owner abandons packet: timeout, then the other requester.
    sel = 1;
    do_reset();
    add_byte(0, 8'h11, 1'b0);
    add_byte(1, 8'h22, 1'b1);
    drive();
    run_idle(100, "tmo");
    compare("tmo", 2);
    check("tmo pulses", terr_cnt, 1);
    check("tmo cycle", terr_cyc, obs_cyc[0] + H + 17);

    // Owner transfers exactly on the expiry cycle: no timeout.
    do_reset();
    add_byte(0, 8'h11, 1'b0);
    add_byte(1, 8'h22, 1'b1);
    drive();
    n = 0;
    while (n_obs < 1 && n < 50) begin
      step();
      n++;
    end
    while (cyc < obs_cyc[0] + H + 16) step();
    add_byte(0, 8'h33, 1'b1);
    drive();
    run_idle(100, "edge");
    compare("edge", 2);
    check("edge no timeout", terr_cnt, 0);

    // Reset asserted in PULSE.
    sel = 0;
    do_reset();
    add_byte(0, 8'hC1, 1'b0); add_byte(0, 8'hC2, 1'b0); add_byte(0, 8'hC3, 1'b1);
    drive();
    n = 0;
    while (s_ready == 4'b0000 && n < 50) begin
      step();
      n++;
    end
    check("rstP in pulse", m_tx_en, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_outputs("rstP");
    clear_queues();
    drive();
    n_obs = 0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rstP no pulse", n_obs, 0);
    add_byte(1, 8'hD1, 1'b0); add_byte(1, 8'hD2, 1'b1);
    drive();
    run_idle(100, "rstP");
    compare("rstP", 2);

    // Reset asserted in HOLD.
    do_reset();
    add_byte(0, 8'hE1, 1'b0); add_byte(0, 8'hE2, 1'b1);
    drive();
    n = 0;
    while (s_ready == 4'b0000 && n < 50) begin
      step();
      n++;
    end
    step();
    check("rstH busy before", m_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    reset_outputs("rstH");
    clear_queues();
    drive();
    n_obs = 0;
    repeat (3) step();
    rst_n = 1'b1;
    check("rstH no pulse", n_obs, 0);
    add_byte(1, 8'hF1, 1'b1);
    add_byte(0, 8'hF0, 1'b1);
    drive();
    run_idle(100, "rstH");
    compare("rstH", 2);
    check("rstH first owner", obs_src[0], 0);

    // Four requesters, single-byte packets.
    sel = 2;
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 4; r++) add_byte(r, 8'($urandom), 1'b1);
    drive();
    run_idle(300, "n4");
    compare("n4", 4);
    for (int i = 0; i < 8; i++) check($sformatf("n4 order[%0d]", i), obs_src[i], i % 4);

    // Randomized packets and UART readiness, two requesters.
    sel = 0;
    do_reset();
    rdy_rand = 1'b1;
    for (int p = 0; p < 3; p++)
      for (int r = 0; r < 2; r++) begin
        n = int'($urandom_range(1, 4));
        for (int b = 0; b < n; b++) add_byte(r, 8'($urandom), 1'(b == n - 1));
      end
    drive();
    run_idle(3000, "rnd2");
    compare("rnd2", 2);

    // Randomized, four requesters.
    sel = 2;
    do_reset();
    rdy_rand = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 4; r++) begin
        n = int'($urandom_range(1, 3));
        for (int b = 0; b < n; b++) add_byte(r, 8'($urandom), 1'(b == n - 1));
      end
    drive();
    run_idle(3000, "rnd4");
    compare("rnd4", 4);

    check("pulse spacing violations", spacing_viol, 0);
    check("non-owner ready violations", ready_viol, 0);
    check("waddr violations", waddr_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmitter between several byte-stream producers: the periodic register dumper, a debug message source, and future sources. Each producer presents bytes through a valid/ready handshake and marks packet ends with `last`. The arbiter grants the transmitter round-robin with packet locking, so packets are never interleaved. It sequences the UART core's write interface: THR address, data, a one-cycle write-enable pulse, then a holdoff before `TxRDYn` is sampled again.

## Interface
- `N_REQ`, default 2: number of requesters, 2..8.
- `HOLDOFF`, default 4: cycles after a write pulse before `tx_rdy_n` is sampled again (≥1).
- `TIMEOUT`, default 27_000_000: idle cycles mid-packet before the lock is forcibly released (≥2).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in N_REQ: requester i has a byte on `req_data[i]`.
- `req_data` in N_REQ×8: per-requester byte.
- `req_last` in N_REQ: the byte is the final byte of its packet.
- `req_ready` out N_REQ: the byte of requester i is accepted this cycle (transfer = valid & ready).
- `tx_rdy_n` in 1: UART `TxRDYn`; low = transmit holding register free.
- `tx_en` out 1: one-cycle write pulse to UART `I_TX_EN`.
- `waddr` out 3: UART `I_WADDR`, always the THR address 3'b000.
- `wdata` out 8: UART `I_WDATA`.
- `grant` out $clog2(N_REQ) (min 1): index of the current owner.
- `busy` out 1: a packet lock is held.
- `timeout_err` out 1: one-cycle pulse when a lock is dropped by timeout.

## Operation
- States:
  - ARB: no owner.
  - WAIT: owner locked, waiting for a byte and for the UART to be ready.
  - PULSE: `tx_en` high.
  - HOLD: holdoff counting.
- ARB:
  - If any `req_valid` is set, pick the first set bit, searching from `rr_ptr` upward with wrap.
  - Set `grant` and `busy`=1, then go to WAIT. No byte is accepted in ARB.
- WAIT:
  - `req_ready[grant]` = (`tx_rdy_n`==0). This is combinational and only for the owner. All other `req_ready` bits are 0.
  - On transfer: latch `wdata`←`req_data[grant]` and the last flag, then go to PULSE.
- PULSE: `tx_en`=1 for exactly one cycle, `waddr`=0. Then go to HOLD and load the holdoff counter with HOLDOFF−1.
- HOLD: count down to 0.
  - If the latched last flag is set: go to ARB, set `busy`=0, and `rr_ptr`←(`grant`+1) mod N_REQ.
  - Otherwise: go to WAIT.
- Timeout:
  - The idle counter runs in WAIT whenever no transfer occurs. It clears on a transfer and on leaving WAIT.
  - When it reaches TIMEOUT−1: pulse `timeout_err`, release the lock (go to ARB, `busy`=0), and advance `rr_ptr` as for `last`.
- A transfer in the same cycle as timeout expiry takes priority: the byte is sent and no error is raised.
- `req_valid` of non-owners is ignored while a lock is held. Requesters must hold data stable until ready.
- `tx_rdy_n` is ignored outside WAIT.
- Reset:
  - `tx_en`=0, `waddr`=0, `wdata`=0, `grant`=0, `busy`=0, `timeout_err`=0, `req_ready`=0.
  - `rr_ptr`=0, state ARB, all counters 0.
  - Reset mid-packet abandons the packet immediately. No pulse is emitted after reset assertion.

## Timing
- Transfer in WAIT at cycle T:
  - `tx_en`=1 in cycle T+1 with `wdata` already valid.
  - Earliest next `req_ready` is at T+2+HOLDOFF.
- Request at cycle T with the arbiter in ARB: grant at T+1, earliest transfer at T+1.
- Maximum byte rate: 1 per (HOLDOFF+2) cycles. In practice the UART serial rate dominates.
- After the final HOLD: ARB for one cycle, then the new grant.
- With both requesters continuously valid, grants strictly alternate packet by packet.
- The `rr_ptr` wrap from N_REQ−1 goes to 0.

## Structure
- Package `uart_arb_pkg`:
  - `arb_state_t` enum {ARB, WAIT, PULSE, HOLD}.
  - `UART_THR_ADDR`=3'b000.
  - Default `HOLDOFF` and `TIMEOUT` constants.
- Sub-module `rr_pick`:
  - Combinational rotate-priority encoder with parameter N.
  - Inputs `req[N]` and `ptr`; outputs `idx` and `any`.
- The top level holds the FSM, counters, data latch and output registers.

## Test plan
- Single requester, packet 0x72,0x65,0x0A (last on 0x0A), `tx_rdy_n`=0:
  - Exactly three `tx_en` pulses with `wdata` 0x72,0x65,0x0A, each HOLDOFF+2 cycles apart.
  - `busy` falls after the third.
- Req0 and req1 both valid from the same cycle, 2-byte packets each, repeated:
  - Pulse order req0,req0,req1,req1,req0,…
  - Never interleaved; `grant` alternates.
- `tx_rdy_n` held high for 100 cycles in WAIT with valid data:
  - No `req_ready` and no `tx_en` during the stall.
  - Transfer in the first cycle after it falls; `tx_en` the following cycle.
- Owner drops `req_valid` mid-packet, TIMEOUT=16:
  - `timeout_err` pulses once after 16 idle WAIT cycles.
  - The other requester is granted next; it also wins at the exact expiry cycle only if the owner does not transfer.
- `rst_n` asserted in PULSE and in HOLD:
  - All outputs at reset values asynchronously, with no extra pulse.
  - After release, a req1 packet is granted first only when req0 is idle.
- N_REQ=4, all requesters valid with single-byte packets:
  - Grant sequence 0,1,2,3,0 (`rr_ptr` wraps).
  - `req_ready` is never high for a non-owner.
